regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 148 ++++++++++++++
 tb/tb_regfile_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register pending-write scoreboard.
// Decode claims a destination register when it issues a writing instruction.
// Writeback retires the claim and writes the data.
// A read operand is hazardous while any write to its register is still outstanding,
// except when the last outstanding write is being bypassed in the same cycle.
module regfile_scoreboard #(
    parameter int NREGS   = 8,
    parameter int MAXPEND = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] read1RegSel,
    input  logic [$clog2(NREGS)-1:0] read2RegSel,
    output logic [15:0]              read1Data,
    output logic [15:0]              read2Data,
    output logic                     hazard1,
    output logic                     hazard2,
    input  logic                     claimEn,
    input  logic [$clog2(NREGS)-1:0] claimRegSel,
    input  logic                     writeEn,
    input  logic [$clog2(NREGS)-1:0] writeRegSel,
    input  logic [15:0]              writeData,
    input  logic                     flush,
    output logic                     err
);

    localparam int SELW = $clog2(NREGS);
    localparam int PW   = $clog2(MAXPEND + 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAXPEND);
    localparam logic [PW-1:0] PEND_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);

    logic [15:0]      regs_r     [NREGS];
    logic [PW-1:0]    pend_r     [NREGS];
    logic [PW-1:0]    pend_nxt_s [NREGS];
    logic [NREGS-1:0] claim_hit_s;
    logic [NREGS-1:0] write_hit_s;
    logic             err_r;
    logic             err_set_s;
    logic             byp1_s;
    logic             byp2_s;

    // An operand stays hazardous while writes are outstanding, unless the only one left is bypassed now.
    function automatic logic hazard_calc(input logic [PW-1:0] pend, input logic byp);
        logic busy;
        busy = 1'b0;
        if (pend == PEND_ZERO) begin
            busy = 1'b0;
        end else if ((pend == PEND_ONE) && byp) begin
            busy = 1'b0;
        end else begin
            busy = 1'b1;
        end
        return busy;
    endfunction

    // Decode which counters see a claim or a write this cycle; a flush cancels the claim.
    always_comb begin
        claim_hit_s = {NREGS{1'b0}};
        write_hit_s = {NREGS{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            claim_hit_s[i] = claimEn && !flush && (claimRegSel == SELW'(i));
            write_hit_s[i] = writeEn && (writeRegSel == SELW'(i));
        end
    end

    // Next pending counts, saturating at both ends and flagging over/underflow.
    always_comb begin
        err_set_s = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            pend_nxt_s[i] = pend_r[i];
            if (flush) begin
                pend_nxt_s[i] = PEND_ZERO;
            end else if (claim_hit_s[i] && !write_hit_s[i]) begin
                if (pend_r[i] == PEND_MAX) begin
                    err_set_s = 1'b1;
                end else begin
                    pend_nxt_s[i] = pend_r[i] + PEND_ONE;
                end
            end else if (write_hit_s[i] && !claim_hit_s[i]) begin
                if (pend_r[i] == PEND_ZERO) begin
                    err_set_s = 1'b1;
                end else begin
                    pend_nxt_s[i] = pend_r[i] - PEND_ONE;
                end
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
    end

    // Register array, scoreboard counters and sticky error; reset discards everything, including a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= 16'h0000;
                pend_r[i] <= PEND_ZERO;
            end
            err_r <= 1'b0;
        end else begin
            if (writeEn) begin
                regs_r[writeRegSel] <= writeData;
            end
            for (int i = 0; i < NREGS; i++) begin
                pend_r[i] <= pend_nxt_s[i];
            end
            err_r <= err_r | err_set_s;
        end
    end

    // Same-cycle writeback bypass detection for both read ports.
    always_comb begin
        byp1_s = writeEn && (writeRegSel == read1RegSel);
        byp2_s = writeEn && (writeRegSel == read2RegSel);
    end

    // Read port 1: bypassed data and hazard, forced quiet while reset is held.
    always_comb begin
        if (!rst) begin
            read1Data = 16'h0000;
            hazard1   = 1'b0;
        end else begin
            read1Data = byp1_s ? writeData : regs_r[read1RegSel];
            hazard1   = hazard_calc(pend_r[read1RegSel], byp1_s);
        end
    end

    // Read port 2: bypassed data and hazard, forced quiet while reset is held.
    always_comb begin
        if (!rst) begin
            read2Data = 16'h0000;
            hazard2   = 1'b0;
        end else begin
            read2Data = byp2_s ? writeData : regs_r[read2RegSel];
            hazard2   = hazard_calc(pend_r[read2RegSel], byp2_s);
        end
    end

    // Error flag reads as clear while reset is held.
    always_comb begin
        if (!rst) begin
            err = 1'b0;
        end else begin
            err = err_r;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard.
// First phase: a table of directed cycles with hand-derived expected outputs.
// Second phase: random traffic compared against an outstanding-write count model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [2:0]  read1RegSel, read2RegSel, claimRegSel, writeRegSel;
    logic [15:0] read1Data, read2Data, writeData;
    logic        hazard1, hazard2, claimEn, writeEn, flush, err;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_scoreboard #(.NREGS(8), .MAXPEND(3)) dut (
        .clk(clk), .rst(rst),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Data(read1Data), .read2Data(read2Data),
        .hazard1(hazard1), .hazard2(hazard2),
        .claimEn(claimEn), .claimRegSel(claimRegSel),
        .writeEn(writeEn), .writeRegSel(writeRegSel), .writeData(writeData),
        .flush(flush), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [2:0]  r1, r2;
        logic        ce;
        logic [2:0]  cs;
        logic        we;
        logic [2:0]  ws;
        logic [15:0] wd;
        logic        fl;
        logic [15:0] e_d1, e_d2;
        logic        e_h1, e_h2, e_err;
    } vec_t;

    vec_t vecs[31];

    // Reference state: register values, outstanding write counts, sticky error.
    logic [15:0] m_regs[8];
    int          m_pend[8];
    logic        m_err;

    function automatic vec_t mk(input logic rs, input logic [2:0] r1, input logic [2:0] r2,
                                input logic ce, input logic [2:0] cs,
                                input logic we, input logic [2:0] ws, input logic [15:0] wd,
                                input logic fl, input logic [15:0] d1, input logic [15:0] d2,
                                input logic h1, input logic h2, input logic e);
        vec_t v;
        v.rst = rs; v.r1 = r1; v.r2 = r2; v.ce = ce; v.cs = cs;
        v.we = we; v.ws = ws; v.wd = wd; v.fl = fl;
        v.e_d1 = d1; v.e_d2 = d2; v.e_h1 = h1; v.e_h2 = h2; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; read1RegSel = v.r1; read2RegSel = v.r2;
        claimEn = v.ce; claimRegSel = v.cs;
        writeEn = v.we; writeRegSel = v.ws; writeData = v.wd; flush = v.fl;
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = 16'h0000;
                m_pend[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            if (writeEn) m_regs[writeRegSel] = writeData;
            for (int i = 0; i < 8; i++) begin
                int n;
                if (flush) begin
                    m_pend[i] = 0;
                end else begin
                    n = m_pend[i];
                    if (claimEn && claimRegSel == 3'(i)) n = n + 1;
                    if (writeEn && writeRegSel == 3'(i)) n = n - 1;
                    if (n > 3) begin n = 3; m_err = 1'b1; end
                    if (n < 0) begin n = 0; m_err = 1'b1; end
                    m_pend[i] = n;
                end
            end
        end
    endtask

    function automatic logic [15:0] model_data(input logic [2:0] sel);
        if (!rst) return 16'h0000;
        if (writeEn && writeRegSel == sel) return writeData;
        return m_regs[sel];
    endfunction

    function automatic logic model_haz(input logic [2:0] sel);
        if (!rst) return 1'b0;
        if (m_pend[sel] == 0) return 1'b0;
        if (m_pend[sel] == 1 && writeEn && writeRegSel == sel) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 16'h0000;
            m_pend[i] = 0;
        end
        m_err = 1'b0;

        //            rst r1   r2   ce   cs   we   ws   wd        fl    d1        d2        h1   h2   err
        vecs[0]  = mk(1'b0,3'd0,3'd0,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        vecs[1]  = mk(1'b1,3'd3,3'd0,1'b1,3'd3,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        vecs[2]  = mk(1'b1,3'd3,3'd0,1'b0,3'd0,1'b1,3'd3,16'h1234,1'b0,16'h1234,16'h0000,1'b0,1'b0,1'b0);
        vecs[3]  = mk(1'b1,3'd3,3'd0,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h1234,16'h0000,1'b0,1'b0,1'b0);
        vecs[4]  = mk(1'b1,3'd3,3'd5,1'b1,3'd5,1'b0,3'd0,16'h0000,1'b0,16'h1234,16'h0000,1'b0,1'b0,1'b0);
        vecs[5]  = mk(1'b1,3'd3,3'd5,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h1234,16'h0000,1'b0,1'b1,1'b0);
        vecs[6]  = mk(1'b1,3'd3,3'd5,1'b0,3'd0,1'b1,3'd5,16'hBEEF,1'b0,16'h1234,16'hBEEF,1'b0,1'b0,1'b0);
        vecs[7]  = mk(1'b1,3'd6,3'd5,1'b0,3'd0,1'b1,3'd6,16'h0606,1'b0,16'h0606,16'hBEEF,1'b0,1'b0,1'b0);
        vecs[8]  = mk(1'b1,3'd6,3'd5,1'b1,3'd1,1'b0,3'd0,16'h0000,1'b0,16'h0606,16'hBEEF,1'b0,1'b0,1'b1);
        vecs[9]  = mk(1'b1,3'd1,3'd5,1'b1,3'd1,1'b1,3'd1,16'h0101,1'b0,16'h0101,16'hBEEF,1'b0,1'b0,1'b1);
        vecs[10] = mk(1'b1,3'd1,3'd5,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h0101,16'hBEEF,1'b1,1'b0,1'b1);
        vecs[11] = mk(1'b1,3'd1,3'd5,1'b1,3'd7,1'b0,3'd0,16'h0000,1'b0,16'h0101,16'hBEEF,1'b1,1'b0,1'b1);
        vecs[12] = mk(1'b0,3'd1,3'd7,1'b1,3'd2,1'b1,3'd4,16'h4444,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        vecs[13] = mk(1'b1,3'd4,3'd7,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        vecs[14] = mk(1'b1,3'd1,3'd3,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        vecs[15] = mk(1'b1,3'd2,3'd0,1'b1,3'd2,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        vecs[16] = mk(1'b1,3'd2,3'd0,1'b1,3'd2,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0);
        vecs[17] = mk(1'b1,3'd2,3'd0,1'b1,3'd2,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0);
        vecs[18] = mk(1'b1,3'd2,3'd0,1'b1,3'd2,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0);
        vecs[19] = mk(1'b1,3'd2,3'd0,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b1);
        vecs[20] = mk(1'b1,3'd2,3'd0,1'b0,3'd0,1'b1,3'd2,16'h0011,1'b0,16'h0011,16'h0000,1'b1,1'b0,1'b1);
        vecs[21] = mk(1'b1,3'd2,3'd0,1'b0,3'd0,1'b1,3'd2,16'h0022,1'b0,16'h0022,16'h0000,1'b1,1'b0,1'b1);
        vecs[22] = mk(1'b1,3'd2,3'd0,1'b0,3'd0,1'b1,3'd2,16'h0033,1'b0,16'h0033,16'h0000,1'b0,1'b0,1'b1);
        vecs[23] = mk(1'b1,3'd2,3'd0,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h0033,16'h0000,1'b0,1'b0,1'b1);
        vecs[24] = mk(1'b0,3'd2,3'd0,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        vecs[25] = mk(1'b1,3'd4,3'd7,1'b1,3'd4,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b0,1'b0,1'b0);
        vecs[26] = mk(1'b1,3'd4,3'd7,1'b1,3'd7,1'b0,3'd0,16'h0000,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b0);
        vecs[27] = mk(1'b1,3'd4,3'd7,1'b1,3'd0,1'b1,3'd4,16'h00FF,1'b1,16'h00FF,16'h0000,1'b0,1'b1,1'b0);
        vecs[28] = mk(1'b1,3'd4,3'd0,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h00FF,16'h0000,1'b0,1'b0,1'b0);
        vecs[29] = mk(1'b1,3'd3,3'd4,1'b0,3'd0,1'b1,3'd3,16'h3333,1'b1,16'h3333,16'h00FF,1'b0,1'b0,1'b0);
        vecs[30] = mk(1'b1,3'd3,3'd0,1'b0,3'd0,1'b0,3'd0,16'h0000,1'b0,16'h3333,16'h0000,1'b0,1'b0,1'b0);

        drive(vecs[0]);
        @(posedge clk);
        model_edge();
        #1;

        // Directed table: drive, sample mid-cycle, then let the edge commit.
        for (int k = 0; k < 31; k++) begin
            drive(vecs[k]);
            #3;
            chk($sformatf("vec%0d read1Data", k), read1Data, vecs[k].e_d1);
            chk($sformatf("vec%0d read2Data", k), read2Data, vecs[k].e_d2);
            chk($sformatf("vec%0d hazard1", k), 16'(hazard1), 16'(vecs[k].e_h1));
            chk($sformatf("vec%0d hazard2", k), 16'(hazard2), 16'(vecs[k].e_h2));
            chk($sformatf("vec%0d err", k), 16'(err), 16'(vecs[k].e_err));
            @(posedge clk);
            model_edge();
            #1;
        end

        // Random traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            rst         = ($urandom_range(0, 39) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            claimEn     = ($urandom_range(0, 1) == 1);
            writeEn     = ($urandom_range(0, 1) == 1);
            claimRegSel = 3'($urandom_range(0, 7));
            writeRegSel = 3'($urandom_range(0, 7));
            writeData   = 16'($urandom);
            read1RegSel = ($urandom_range(0, 3) == 0) ? writeRegSel : 3'($urandom_range(0, 7));
            read2RegSel = ($urandom_range(0, 3) == 0) ? claimRegSel : 3'($urandom_range(0, 7));
            #3;
            chk("rnd read1Data", read1Data, model_data(read1RegSel));
            chk("rnd read2Data", read2Data, model_data(read2RegSel));
            chk("rnd hazard1", 16'(hazard1), 16'(model_haz(read1RegSel)));
            chk("rnd hazard2", 16'(hazard2), 16'(model_haz(read2RegSel)));
            chk("rnd err", 16'(err), 16'(rst ? m_err : 1'b0));
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
